// File: rtl/if_stage.sv
// Instruction fetch stage: one bus access per instruction, with a hold
// buffer for stalled returns and a drain state for flushed accesses.
module if_stage #(
    parameter logic [29:0] RESET_VECTOR = 30'h0000_0000,
    parameter logic [31:0] NOP_INSN     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic [29:0] NewPC,
    input  logic        BrTaken,
    input  logic [29:0] BrAddr,
    output logic        BusReq,
    output logic [29:0] BusAddr,
    input  logic        BusRdy,
    input  logic [31:0] BusRdData,
    output logic [29:0] IFPC,
    output logic [31:0] IFInsn,
    output logic        IFEn,
    output logic        IFBusy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [29:0] fpc_q, fpc_d;
    logic [29:0] ifpc_q, ifpc_d;
    logic [31:0] ifinsn_q, ifinsn_d;
    logic        ifen_q, ifen_d;
    logic [29:0] hpc_q, hpc_d;
    logic [31:0] hinsn_q, hinsn_d;
    logic        pend_vld_q, pend_vld_d;
    logic [29:0] pend_q, pend_d;
    logic [29:0] redir_q, redir_d;
    logic [29:0] nxt_pc;

    assign BusReq  = (state_q == FETCH) || (state_q == DISCARD);
    assign BusAddr = fpc_q;
    assign IFBusy  = BusReq && !BusRdy;
    assign IFPC    = ifpc_q;
    assign IFInsn  = ifinsn_q;
    assign IFEn    = ifen_q;

    // A same-cycle branch beats an older latched target
    assign nxt_pc = BrTaken    ? BrAddr :
                    pend_vld_q ? pend_q : fpc_q + 30'd1;

    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        ifpc_d     = ifpc_q;
        ifinsn_d   = ifinsn_q;
        ifen_d     = ifen_q;
        hpc_d      = hpc_q;
        hinsn_d    = hinsn_q;
        pend_vld_d = pend_vld_q;
        pend_d     = pend_q;
        redir_d    = redir_q;
        if (Flush) begin
            ifinsn_d   = NOP_INSN;
            ifen_d     = 1'b0;
            pend_vld_d = 1'b0;
            unique case (state_q)
                FETCH, DISCARD: begin
                    if (BusRdy) begin
                        state_d = FETCH;
                        fpc_d   = NewPC;
                    end else begin
                        // keep the old address on the bus until it drains
                        state_d = DISCARD;
                        redir_d = NewPC;
                    end
                end
                default: begin
                    state_d = FETCH;
                    fpc_d   = NewPC;
                end
            endcase
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = FETCH;
                    if (BrTaken) fpc_d = BrAddr;
                end
                FETCH: begin
                    if (BusRdy) begin
                        fpc_d      = nxt_pc;
                        pend_vld_d = 1'b0;
                        if (Stall) begin
                            hpc_d   = fpc_q;
                            hinsn_d = BusRdData;
                            state_d = HOLD;
                        end else begin
                            ifpc_d   = fpc_q;
                            ifinsn_d = BusRdData;
                            ifen_d   = 1'b1;
                            state_d  = IDLE;
                        end
                    end else if (BrTaken) begin
                        pend_vld_d = 1'b1;
                        pend_d     = BrAddr;
                    end
                end
                HOLD: begin
                    if (BrTaken) fpc_d = BrAddr;
                    if (!Stall) begin
                        ifpc_d   = hpc_q;
                        ifinsn_d = hinsn_q;
                        ifen_d   = 1'b1;
                        state_d  = FETCH;
                    end
                end
                DISCARD: begin
                    if (BusRdy) begin
                        state_d = FETCH;
                        fpc_d   = redir_q;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fpc_q      <= RESET_VECTOR;
            ifpc_q     <= 30'h0;
            ifinsn_q   <= NOP_INSN;
            ifen_q     <= 1'b0;
            hpc_q      <= 30'h0;
            hinsn_q    <= NOP_INSN;
            pend_vld_q <= 1'b0;
            pend_q     <= 30'h0;
            redir_q    <= 30'h0;
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            ifpc_q     <= ifpc_d;
            ifinsn_q   <= ifinsn_d;
            ifen_q     <= ifen_d;
            hpc_q      <= hpc_d;
            hinsn_q    <= hinsn_d;
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
            redir_q    <= redir_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, stall hold, branch,
// flush drain, address wrap and mid-access reset.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall, Flush, BrTaken;
    logic [29:0] NewPC, BrAddr;
    logic        BusReq, BusRdy;
    logic [29:0] BusAddr;
    logic [31:0] BusRdData;
    logic [29:0] IFPC;
    logic [31:0] IFInsn;
    logic        IFEn, IFBusy;

    int total = 0;
    int bad   = 0;
    int lat   = 1;
    int cnt;
    int acc5;

    if_stage dut (
        .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush),
        .NewPC(NewPC), .BrTaken(BrTaken), .BrAddr(BrAddr),
        .BusReq(BusReq), .BusAddr(BusAddr), .BusRdy(BusRdy),
        .BusRdData(BusRdData), .IFPC(IFPC), .IFInsn(IFInsn),
        .IFEn(IFEn), .IFBusy(IFBusy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [29:0] a);
        if (a == 30'd5) return 32'hAAAA_0005;
        return {2'b00, a} + 32'h100;
    endfunction

    // latency: BusRdy rises once the request has been up for lat cycles
    always @(posedge clk or posedge reset) begin
        if (reset) cnt <= 0;
        else if (!BusReq || BusRdy) cnt <= 0;
        else cnt <= cnt + 1;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) acc5 <= 0;
        else if (BusReq && BusRdy && BusAddr == 30'd5) acc5 <= acc5 + 1;
    end

    assign BusRdy    = BusReq && (cnt >= lat - 1);
    assign BusRdData = BusRdy ? mem(BusAddr) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; Stall = 1'b0; Flush = 1'b0; BrTaken = 1'b0;
        NewPC = '0; BrAddr = '0;
        #1;
        chk("rst_en",   {31'b0, IFEn}, 32'd0);
        chk("rst_insn", IFInsn, 32'h0);
        chk("rst_pc",   {2'b0, IFPC}, 32'h0);
        chk("rst_req",  {31'b0, BusReq}, 32'd0);
        chk("rst_busy", {31'b0, IFBusy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // sequential fetch, one instruction per two cycles
        tick(); // edge1
        chk("e1_req",  {31'b0, BusReq}, 32'd1);
        chk("e1_addr", {2'b0, BusAddr}, 32'h0);
        chk("e1_en",   {31'b0, IFEn}, 32'd0);
        tick(); // edge2
        chk("e2_pc",   {2'b0, IFPC}, 32'h0);
        chk("e2_insn", IFInsn, 32'h100);
        chk("e2_en",   {31'b0, IFEn}, 32'd1);
        chk("e2_req",  {31'b0, BusReq}, 32'd0);
        tick(); tick(); // edge4
        chk("e4_pc",   {2'b0, IFPC}, 32'h1);
        chk("e4_insn", IFInsn, 32'h101);
        tick(); tick(); // edge6
        chk("e6_pc",   {2'b0, IFPC}, 32'h2);
        chk("e6_insn", IFInsn, 32'h102);
        tick(); tick(); tick(); tick(); tick(); // edge11
        chk("e11_addr", {2'b0, BusAddr}, 32'h5);

        // stall across the return of address 5
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_req",  {31'b0, BusReq}, 32'd0);
            chk("hold_pc",   {2'b0, IFPC}, 32'h4);
            chk("hold_insn", IFInsn, 32'h104);
        end
        Stall = 1'b0;
        tick(); // edge15
        chk("rel_pc",   {2'b0, IFPC}, 32'h5);
        chk("rel_insn", IFInsn, 32'hAAAA_0005);
        chk("rel_addr", {2'b0, BusAddr}, 32'h6);
        chk("rel_acc5", acc5, 32'd1);

        // branch during an outstanding fetch of 7
        tick(); // edge16
        chk("e16_pc", {2'b0, IFPC}, 32'h6);
        lat = 3;
        tick(); // edge17
        chk("br_addr7", {2'b0, BusAddr}, 32'h7);
        chk("br_busy",  {31'b0, IFBusy}, 32'd1);
        BrTaken = 1'b1; BrAddr = 30'h40;
        tick(); // edge18
        BrTaken = 1'b0;
        chk("br_stay7", {2'b0, BusAddr}, 32'h7);
        tick(); tick(); // edge20
        chk("br_pc7",   {2'b0, IFPC}, 32'h7);
        chk("br_insn7", IFInsn, 32'h107);
        tick(); // edge21
        chk("br_tgt",   {2'b0, BusAddr}, 32'h40);
        tick(); tick(); tick(); // edge24
        chk("br_pc40",  {2'b0, IFPC}, 32'h40);

        // flush in idle, then flush an outstanding access
        Flush = 1'b1; NewPC = 30'h10;
        tick(); // edge25
        chk("fl_addr10", {2'b0, BusAddr}, 32'h10);
        chk("fl_en0",    {31'b0, IFEn}, 32'd0);
        NewPC = 30'h200;
        tick(); // edge26
        Flush = 1'b0;
        chk("dis_req",  {31'b0, BusReq}, 32'd1);
        chk("dis_addr", {2'b0, BusAddr}, 32'h10);
        chk("dis_busy", {31'b0, IFBusy}, 32'd1);
        chk("dis_en",   {31'b0, IFEn}, 32'd0);
        chk("dis_insn", IFInsn, 32'h0);
        tick(); // edge27
        chk("dis_addr2", {2'b0, BusAddr}, 32'h10);
        chk("dis_rdy",   {31'b0, IFBusy}, 32'd0);
        tick(); // edge28
        chk("dis_new",  {2'b0, BusAddr}, 32'h200);
        chk("dis_drop", {31'b0, IFEn}, 32'd0);

        // flush coinciding with BusRdy, then wrap at the top address
        lat = 1;
        Flush = 1'b1; NewPC = 30'h3FFF_FFFF;
        tick(); // edge29
        Flush = 1'b0;
        chk("flr_drop", IFInsn, 32'h0);
        chk("flr_addr", {2'b0, BusAddr}, 32'h3FFF_FFFF);
        tick(); // edge30
        chk("wr_pc",   {2'b0, IFPC}, 32'h3FFF_FFFF);
        chk("wr_insn", IFInsn, 32'h4000_00FF);
        tick(); // edge31
        chk("wr_addr", {2'b0, BusAddr}, 32'h0);
        chk("wr_req",  {31'b0, BusReq}, 32'd1);

        // reset in the middle of an access
        lat = 3;
        tick(); // edge32
        #2;
        reset = 1'b1;
        #1;
        chk("mr_req",  {31'b0, BusReq}, 32'd0);
        chk("mr_en",   {31'b0, IFEn}, 32'd0);
        chk("mr_pc",   {2'b0, IFPC}, 32'h0);
        chk("mr_insn", IFInsn, 32'h0);
        chk("mr_busy", {31'b0, IFBusy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("mr_refetch", {2'b0, BusAddr}, 32'h0);
        chk("mr_rereq",   {31'b0, BusReq}, 32'd1);
        tick(); tick(); tick();
        chk("mr_pc0",   {2'b0, IFPC}, 32'h0);
        chk("mr_insn0", IFInsn, 32'h100);
        chk("mr_en1",   {31'b0, IFEn}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
